// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for ALUSystem: fetches two-byte instructions through the IR
// and sequences microsteps, each held STEP_CYCLES clocks with writes on the final cycle only.
module control_sequencer #(
  parameter int unsigned STEP_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir_out,
  input  logic [3:0]  alu_flags,
  output logic [2:0]  rf_o1sel,
  output logic [2:0]  rf_o2sel,
  output logic [1:0]  rf_funsel,
  output logic [3:0]  rf_rsel,
  output logic [3:0]  rf_tsel,
  output logic [3:0]  alu_funsel,
  output logic [1:0]  arf_outasel,
  output logic [1:0]  arf_outbsel,
  output logic [1:0]  arf_funsel,
  output logic [3:0]  arf_rsel,
  output logic        ir_lh,
  output logic        ir_enable,
  output logic [1:0]  ir_funsel,
  output logic        mem_wr,
  output logic        mem_cs,
  output logic [1:0]  mux_a_sel,
  output logic [1:0]  mux_b_sel,
  output logic        mux_c_sel,
  output logic        halted,
  output logic [2:0]  state
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);

  localparam logic [3:0] OP_LDI = 4'h0, OP_LDM = 4'h1, OP_STM = 4'h2, OP_ADD = 4'h3;
  localparam logic [3:0] OP_LSR = 4'hA, OP_INC = 4'hB, OP_DEC = 4'hC, OP_BRA = 4'hD;
  localparam logic [3:0] OP_BEQ = 4'hE, OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC1   = 3'd4,
    S_EXEC2   = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             step_last, last_d;

  logic [2:0] rf_o1sel_d, rf_o2sel_d;
  logic [1:0] rf_funsel_d, arf_outbsel_d, arf_funsel_d, ir_funsel_d, mux_a_sel_d, mux_b_sel_d;
  logic [3:0] rf_rsel_d, rf_tsel_d, alu_funsel_d, arf_rsel_d;
  logic       ir_lh_d, ir_enable_d, mem_wr_d, mem_cs_d, mux_c_sel_d, halted_d;

  logic [3:0] op;
  logic [1:0] rx, ry;
  logic [3:0] rsel_rx;
  logic       is_alu;
  logic       unused_inputs;

  assign op      = ir_out[15:12];
  assign rx      = ir_out[11:10];
  assign ry      = ir_out[9:8];
  assign rsel_rx = 4'b1000 >> rx;
  assign is_alu  = (op >= OP_ADD) && (op <= OP_LSR);
  assign unused_inputs = ^{alu_flags[3:1], ir_out[7:0]};
  assign state   = state_q;

  function automatic logic [3:0] alu_code(input logic [3:0] opc);
    case (opc)
      4'h3:    alu_code = 4'b0100;
      4'h4:    alu_code = 4'b0101;
      4'h5:    alu_code = 4'b0111;
      4'h6:    alu_code = 4'b1000;
      4'h7:    alu_code = 4'b1010;
      4'h8:    alu_code = 4'b0010;
      4'h9:    alu_code = 4'b1011;
      4'hA:    alu_code = 4'b1100;
      default: alu_code = 4'b0000;
    endcase
  endfunction

  // Next state, then the control word for the cycle being entered so outputs stay registered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    z_d           = z_q;
    rf_o1sel_d    = 3'b000;
    rf_o2sel_d    = 3'b000;
    rf_funsel_d   = 2'b00;
    rf_rsel_d     = 4'b0000;
    rf_tsel_d     = 4'b0000;
    alu_funsel_d  = 4'b0000;
    arf_outbsel_d = 2'b00;
    arf_funsel_d  = 2'b00;
    arf_rsel_d    = 4'b0000;
    ir_lh_d       = 1'b0;
    ir_enable_d   = 1'b0;
    ir_funsel_d   = 2'b00;
    mem_wr_d      = 1'b0;
    mem_cs_d      = 1'b1;
    mux_a_sel_d   = 2'b00;
    mux_b_sel_d   = 2'b00;
    mux_c_sel_d   = 1'b0;
    halted_d      = 1'b0;

    step_last = (state_q == S_DECODE) || (cnt_q == LAST_CNT);
    if (step_last) begin
      cnt_d = '0;
      case (state_q)
        S_INIT:    state_d = S_FETCH_L;
        S_FETCH_L: state_d = S_FETCH_H;
        S_FETCH_H: state_d = S_DECODE;
        S_DECODE:  state_d = S_EXEC1;
        S_EXEC1: begin
          if (op == OP_LDM || op == OP_STM) state_d = S_EXEC2;
          else if (op == OP_HLT)            state_d = S_HALT;
          else                              state_d = S_FETCH_L;
        end
        S_EXEC2:   state_d = S_FETCH_L;
        default:   state_d = S_HALT;
      endcase
      if (state_q == S_EXEC1 && is_alu) z_d = alu_flags[0];
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    last_d = (state_d == S_DECODE) || (cnt_d == LAST_CNT);
    case (state_d)
      S_INIT: begin
        if (last_d) begin
          rf_rsel_d  = 4'b1111;
          rf_tsel_d  = 4'b1111;
          arf_rsel_d = 4'b1111;
        end
      end
      S_FETCH_L, S_FETCH_H: begin
        arf_outbsel_d = 2'b11;
        mem_cs_d      = 1'b0;
        ir_funsel_d   = 2'b01;
        ir_lh_d       = (state_d == S_FETCH_H);
        arf_funsel_d  = 2'b10;
        if (last_d) begin
          ir_enable_d = 1'b1;
          arf_rsel_d  = 4'b1000;
        end
      end
      S_EXEC1: begin
        if (op == OP_LDI) begin
          mux_a_sel_d = 2'b10;
          rf_funsel_d = 2'b01;
          if (last_d) rf_rsel_d = rsel_rx;
        end else if (op == OP_LDM || op == OP_STM) begin
          mux_b_sel_d  = 2'b10;
          arf_funsel_d = 2'b01;
          if (last_d) arf_rsel_d = 4'b0100;
        end else if (is_alu) begin
          alu_funsel_d = alu_code(op);
          rf_o1sel_d   = {1'b1, rx};
          rf_o2sel_d   = {1'b1, ry};
          rf_funsel_d  = 2'b01;
          if (last_d) rf_rsel_d = rsel_rx;
        end else if (op == OP_INC || op == OP_DEC) begin
          rf_funsel_d = (op == OP_INC) ? 2'b11 : 2'b10;
          if (last_d) rf_rsel_d = rsel_rx;
        end else if (op == OP_BRA || (op == OP_BEQ && z_q)) begin
          mux_b_sel_d  = 2'b10;
          arf_funsel_d = 2'b01;
          if (last_d) arf_rsel_d = 4'b1000;
        end
      end
      S_EXEC2: begin
        mem_cs_d = 1'b0;
        if (op == OP_LDM) begin
          mux_a_sel_d = 2'b01;
          rf_funsel_d = 2'b01;
          if (last_d) rf_rsel_d = rsel_rx;
        end else begin
          rf_o1sel_d = {1'b1, rx};
          if (last_d) mem_wr_d = 1'b1;
        end
      end
      S_HALT:  halted_d = 1'b1;
      default: ;
    endcase
  end

  // Reset drops every output to the idle word at once, so no partial write survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      z_q         <= 1'b0;
      rf_o1sel    <= 3'b000;
      rf_o2sel    <= 3'b000;
      rf_funsel   <= 2'b00;
      rf_rsel     <= 4'b0000;
      rf_tsel     <= 4'b0000;
      alu_funsel  <= 4'b0000;
      arf_outasel <= 2'b00;
      arf_outbsel <= 2'b00;
      arf_funsel  <= 2'b00;
      arf_rsel    <= 4'b0000;
      ir_lh       <= 1'b0;
      ir_enable   <= 1'b0;
      ir_funsel   <= 2'b00;
      mem_wr      <= 1'b0;
      mem_cs      <= 1'b1;
      mux_a_sel   <= 2'b00;
      mux_b_sel   <= 2'b00;
      mux_c_sel   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      z_q         <= z_d;
      rf_o1sel    <= rf_o1sel_d;
      rf_o2sel    <= rf_o2sel_d;
      rf_funsel   <= rf_funsel_d;
      rf_rsel     <= rf_rsel_d;
      rf_tsel     <= rf_tsel_d;
      alu_funsel  <= alu_funsel_d;
      arf_outasel <= 2'b00;
      arf_outbsel <= arf_outbsel_d;
      arf_funsel  <= arf_funsel_d;
      arf_rsel    <= arf_rsel_d;
      ir_lh       <= ir_lh_d;
      ir_enable   <= ir_enable_d;
      ir_funsel   <= ir_funsel_d;
      mem_wr      <= mem_wr_d;
      mem_cs      <= mem_cs_d;
      mux_a_sel   <= mux_a_sel_d;
      mux_b_sel   <= mux_b_sel_d;
      mux_c_sel   <= mux_c_sel_d;
      halted      <= halted_d;
    end
  end

endmodule
